// File: rtl/judge_seg_display.sv
// Multi-lane judgement display: each lane latches a judgement, shows PF/GD/FL on
// two 7-segment digits for HOLD_CYCLES, then reverts to dashes. PERFECT may blink.
module judge_seg_display #(
  parameter int NUM_LANES    = 2,
  parameter int HOLD_CYCLES  = 25000000,
  parameter int BLINK_CYCLES = 6250000,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_LANES-1:0]    judge_valid,
  input  logic [2*NUM_LANES-1:0]  judge_code,
  input  logic                    blink_en,
  output logic [14*NUM_LANES-1:0] hex_out,
  output logic [NUM_LANES-1:0]    busy
);

  localparam int TW = $clog2(HOLD_CYCLES + 1);
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [TW-1:0] TMR_LOAD   = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TMR_ONE    = TW'(1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
  localparam logic [BW-1:0] BCNT_ONE   = BW'(1);

  // Patterns are stored active-low; POL flips them for active-high boards.
  localparam logic [6:0] POL       = (ACTIVE_LOW != 0) ? 7'b0000000 : 7'b1111111;
  localparam logic [6:0] SEG_P     = 7'b0001100 ^ POL;
  localparam logic [6:0] SEG_F     = 7'b0001110 ^ POL;
  localparam logic [6:0] SEG_G     = 7'b1000010 ^ POL;
  localparam logic [6:0] SEG_D     = 7'b1000000 ^ POL;
  localparam logic [6:0] SEG_L     = 7'b1000111 ^ POL;
  localparam logic [6:0] SEG_DASH  = 7'b0111111 ^ POL;
  localparam logic [6:0] SEG_BLANK = 7'b1111111 ^ POL;

  typedef enum logic {IDLE = 1'b0, SHOW = 1'b1} lane_state_t;

  lane_state_t          st_r   [NUM_LANES];
  lane_state_t          st_s   [NUM_LANES];
  logic [1:0]           code_r [NUM_LANES];
  logic [1:0]           code_s [NUM_LANES];
  logic [TW-1:0]        tmr_r  [NUM_LANES];
  logic [TW-1:0]        tmr_s  [NUM_LANES];
  logic [BW-1:0]        bcnt_r;
  logic [BW-1:0]        bcnt_s;
  logic                 phase_r;
  logic                 phase_s;
  logic [14*NUM_LANES-1:0] hex_r;
  logic [14*NUM_LANES-1:0] hex_s;
  logic [NUM_LANES-1:0] busy_r;
  logic [NUM_LANES-1:0] busy_s;

  // Next lane state, blink phase and the display image of that next state.
  always_comb begin
    if (bcnt_r == BLINK_LAST) begin
      bcnt_s  = {BW{1'b0}};
      phase_s = ~phase_r;
    end else begin
      bcnt_s  = bcnt_r + BCNT_ONE;
      phase_s = phase_r;
    end
    hex_s  = {(14*NUM_LANES){1'b0}};
    busy_s = {NUM_LANES{1'b0}};
    for (int i = 0; i < NUM_LANES; i++) begin
      st_s[i]   = st_r[i];
      code_s[i] = code_r[i];
      tmr_s[i]  = tmr_r[i];
      // A strobe always wins over expiry: reload or immediate clear.
      if (judge_valid[i]) begin
        if (judge_code[2*i +: 2] != 2'b11) begin
          st_s[i]   = SHOW;
          code_s[i] = judge_code[2*i +: 2];
          tmr_s[i]  = TMR_LOAD;
        end else begin
          st_s[i]   = IDLE;
          tmr_s[i]  = {TW{1'b0}};
        end
      end else if (st_r[i] == SHOW) begin
        if (tmr_r[i] != {TW{1'b0}}) begin
          tmr_s[i] = tmr_r[i] - TMR_ONE;
        end else begin
          st_s[i]  = IDLE;
        end
      end else begin
        st_s[i] = IDLE;
      end

      busy_s[i] = (st_s[i] == SHOW);
      if (st_s[i] == SHOW) begin
        case (code_s[i])
          2'b00: begin
            if (blink_en && !phase_s) begin
              hex_s[14*i +: 14] = {SEG_BLANK, SEG_BLANK};
            end else begin
              hex_s[14*i +: 14] = {SEG_P, SEG_F};
            end
          end
          2'b01:   hex_s[14*i +: 14] = {SEG_G, SEG_D};
          2'b10:   hex_s[14*i +: 14] = {SEG_F, SEG_L};
          default: hex_s[14*i +: 14] = {SEG_DASH, SEG_DASH};
        endcase
      end else begin
        hex_s[14*i +: 14] = {SEG_DASH, SEG_DASH};
      end
    end
  end

  // Lane FSMs, blink counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        st_r[i]   <= IDLE;
        code_r[i] <= 2'b00;
        tmr_r[i]  <= {TW{1'b0}};
      end
      bcnt_r  <= {BW{1'b0}};
      phase_r <= 1'b1;
      hex_r   <= {(2*NUM_LANES){SEG_DASH}};
      busy_r  <= {NUM_LANES{1'b0}};
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        st_r[i]   <= st_s[i];
        code_r[i] <= code_s[i];
        tmr_r[i]  <= tmr_s[i];
      end
      bcnt_r  <= bcnt_s;
      phase_r <= phase_s;
      hex_r   <= hex_s;
      busy_r  <= busy_s;
    end
  end

  assign hex_out = hex_r;
  assign busy    = busy_r;

endmodule
